// File: rtl/gpr_file.sv
// RisKy1 general purpose register file with a write-pending scoreboard.
// Two combinational read ports with Write Back bypass; pending bits drive Decode's RAW stall.
module gpr_file #(
  parameter int MAX_GPR = 32,
  parameter int RSZ     = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           Rd_wr,
  input  logic [4:0]     Rd_addr,
  input  logic [RSZ-1:0] Rd_data,
  input  logic [4:0]     Rs1_addr,
  output logic [RSZ-1:0] Rs1_data,
  output logic           Rs1_busy,
  input  logic [4:0]     Rs2_addr,
  output logic [RSZ-1:0] Rs2_data,
  output logic           Rs2_busy,
  input  logic           sb_set,
  input  logic [4:0]     sb_addr,
  input  logic           sb_flush,
  output logic           gpr_err
);

  localparam logic [5:0] LP_NREGS = 6'(MAX_GPR);

  // x0 has no storage and no pending bit; both arrays start at index 1.
  logic [RSZ-1:0]     r_regs [1:MAX_GPR-1];
  logic [MAX_GPR-1:1] r_pending;
  logic               r_err;

  logic               w_wr_oor;
  logic               w_wr_valid;
  logic               w_set_valid;
  logic [MAX_GPR-1:1] w_pending_nxt;
  logic [RSZ-1:0]     w_rs1_stored;
  logic [RSZ-1:0]     w_rs2_stored;
  logic               w_rs1_pend;
  logic               w_rs2_pend;
  logic               w_rs1_hit;
  logic               w_rs2_hit;

  assign w_wr_oor    = Rd_wr && ({1'b0, Rd_addr} >= LP_NREGS);
  assign w_wr_valid  = Rd_wr && (Rd_addr != 5'd0) && !w_wr_oor && !reset_in;
  assign w_set_valid = sb_set && (sb_addr != 5'd0) && ({1'b0, sb_addr} < LP_NREGS);

  // Flush first, then writeback clear, then set: a same-cycle set always wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pending_nxt = sb_flush ? '0 : r_pending;
    for (int i = 1; i < MAX_GPR; i++) begin
      if (w_wr_valid && (Rd_addr == 5'(i))) w_pending_nxt[i] = 1'b0;
      if (w_set_valid && (sb_addr == 5'(i))) w_pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      // NOTE: the storage array is reset here because x1..xN must read 0 after reset;
      // a plain RAM macro could not be used for this file.
      for (int i = 1; i < MAX_GPR; i++) r_regs[i] <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read of r_* in this block sees the pre-edge value.
      for (int i = 1; i < MAX_GPR; i++) begin
        if (w_wr_valid && (Rd_addr == 5'(i))) r_regs[i] <= Rd_data;
      end
      r_pending <= w_pending_nxt;
      r_err     <= w_wr_oor;
    end
  end

  // Address 0 and out-of-range addresses match no entry and fall through to 0.
  always_comb begin
    w_rs1_stored = '0;
    w_rs2_stored = '0;
    w_rs1_pend   = 1'b0;
    w_rs2_pend   = 1'b0;
    for (int i = 1; i < MAX_GPR; i++) begin
      if (Rs1_addr == 5'(i)) begin
        w_rs1_stored = r_regs[i];
        w_rs1_pend   = r_pending[i];
      end
      if (Rs2_addr == 5'(i)) begin
        w_rs2_stored = r_regs[i];
        w_rs2_pend   = r_pending[i];
      end
    end
  end

  // A valid write implies a non-zero in-range address, so a hit is always a real register.
  assign w_rs1_hit = w_wr_valid && (Rd_addr == Rs1_addr);
  assign w_rs2_hit = w_wr_valid && (Rd_addr == Rs2_addr);

  assign Rs1_data = w_rs1_hit ? Rd_data : w_rs1_stored;
  assign Rs2_data = w_rs2_hit ? Rd_data : w_rs2_stored;
  assign Rs1_busy = w_rs1_pend && !w_rs1_hit && !reset_in;
  assign Rs2_busy = w_rs2_pend && !w_rs2_hit && !reset_in;
  assign gpr_err  = r_err;

endmodule
